// File: rtl/comm_pkg.sv
`default_nettype none
// ==== comm_pkg: shared link-layer types and default link parameters (rev 1.0) ====
package comm_pkg;

  typedef enum logic {
    SEARCH = 1'b0,
    LOCK   = 1'b1
  } rx_state_e;

  // Shared with the transmit strobe generator and the PRBS blocks.
  localparam int OS_DEFAULT        = 4;
  localparam int MAX_DELAY_DEFAULT = 512;
  localparam int WINDOW_DEFAULT    = 64;

endpackage
`default_nettype wire

// File: rtl/ref_delay_line.sv
`default_nettype none
// ==== ref_delay_line: enabled shift register with indexed read tap (rev 1.0) ====
module ref_delay_line #(
  parameter int DEPTH = 512,
  parameter int IDX_W = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             shift,
  input  logic             din,
  input  logic [IDX_W-1:0] idx,
  output logic             dout
);

  logic [DEPTH-1:0] line;

  // Bit 0 always holds the newest reference bit, so idx is the delay in symbols.
  always_ff @(posedge clock) begin
    if (reset) begin
      line <= '0;
    end else if (shift) begin
      line <= {line[DEPTH-2:0], din};
    end
  end

  assign dout = line[idx];

endmodule
`default_nettype wire

// File: rtl/rx_control.sv
`default_nettype none
// ==== rx_control: receive sample strobe, channel delay search and BER counters (rev 1.0) ====
module rx_control
  import comm_pkg::*;
#(
  parameter int OS        = OS_DEFAULT,
  parameter int PH_W      = 2,
  parameter int MAX_DELAY = MAX_DELAY_DEFAULT,
  parameter int DLY_W     = 9,
  parameter int WINDOW    = WINDOW_DEFAULT,
  parameter int LOSS_THR  = 8,
  parameter int CNT_W     = 32
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [PH_W-1:0]  i_phase,
  input  logic             i_rx_bit,
  input  logic             i_ref_bit,
  output logic             o_sample_valid,
  output logic             o_lock,
  output logic [DLY_W-1:0] o_delay,
  output logic [CNT_W-1:0] o_err_count,
  output logic [CNT_W-1:0] o_bit_count
);

  localparam int WC_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int WE_W = $clog2(WINDOW + 1);

  logic [PH_W-1:0]  ph_cnt;
  logic [PH_W-1:0]  phase_q;
  logic             sample_hit;
  logic             sample_valid;
  logic             rx_q;
  logic             cmp_pend;
  logic             cmp_en;
  logic             ref_bit;
  logic             err;
  logic             win_end;
  logic [DLY_W-1:0] rd_idx;
  logic [WE_W-1:0]  win_err_sum;

  rx_state_e        state, state_next;
  logic [DLY_W-1:0] cand, cand_next;
  logic [DLY_W-1:0] delay, delay_next;
  logic [WC_W-1:0]  win_cnt, win_cnt_next;
  logic [WE_W-1:0]  win_err, win_err_next;
  logic [CNT_W-1:0] err_count, err_count_next;
  logic [CNT_W-1:0] bit_count, bit_count_next;

  assign sample_hit = i_enable && (ph_cnt == phase_q);
  // The comparison is held off while disabled so a sample taken just before
  // i_enable drops is still evaluated once it returns.
  assign cmp_en     = i_enable && cmp_pend;

  always_ff @(posedge clock) begin
    if (i_reset) begin
      ph_cnt       <= '0;
      phase_q      <= '0;
      sample_valid <= 1'b0;
      rx_q         <= 1'b0;
      cmp_pend     <= 1'b0;
    end else begin
      sample_valid <= sample_hit;
      if (i_enable) begin
        ph_cnt   <= ph_cnt + PH_W'(1);
        cmp_pend <= sample_hit;
        if (ph_cnt == PH_W'(OS - 1)) begin
          phase_q <= i_phase;
        end
      end
      if (sample_hit) begin
        rx_q <= i_rx_bit;
      end
    end
  end

  assign rd_idx = (state == LOCK) ? delay : cand;

  ref_delay_line #(
    .DEPTH (MAX_DELAY),
    .IDX_W (DLY_W)
  ) u_ref_dl (
    .clock (clock),
    .reset (i_reset),
    .shift (sample_hit),
    .din   (i_ref_bit),
    .idx   (rd_idx),
    .dout  (ref_bit)
  );

  assign err         = rx_q ^ ref_bit;
  assign win_err_sum = win_err + WE_W'(err);
  assign win_end     = (win_cnt == WC_W'(WINDOW - 1));

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state     <= SEARCH;
      cand      <= '0;
      delay     <= '0;
      win_cnt   <= '0;
      win_err   <= '0;
      err_count <= '0;
      bit_count <= '0;
    end else begin
      state     <= state_next;
      cand      <= cand_next;
      delay     <= delay_next;
      win_cnt   <= win_cnt_next;
      win_err   <= win_err_next;
      err_count <= err_count_next;
      bit_count <= bit_count_next;
    end
  end

  always_comb begin
    state_next     = state;
    cand_next      = cand;
    delay_next     = delay;
    win_cnt_next   = win_cnt;
    win_err_next   = win_err;
    err_count_next = err_count;
    bit_count_next = bit_count;

    if (cmp_en) begin
      win_cnt_next = win_cnt + WC_W'(1);
      win_err_next = win_err_sum;

      if (state == LOCK) begin
        if (bit_count != '1) begin
          bit_count_next = bit_count + CNT_W'(1);
        end
        if (err && (err_count != '1)) begin
          err_count_next = err_count + CNT_W'(1);
        end
      end

      // Window decisions include the error of the sample closing the window.
      if (win_end) begin
        win_cnt_next = '0;
        win_err_next = '0;
        case (state)
          SEARCH: begin
            if (win_err_sum == '0) begin
              state_next = LOCK;
              delay_next = cand;
            end else if (cand == DLY_W'(MAX_DELAY - 1)) begin
              cand_next = '0;
            end else begin
              cand_next = cand + DLY_W'(1);
            end
          end
          LOCK: begin
            if (win_err_sum > WE_W'(LOSS_THR)) begin
              state_next = SEARCH;
              cand_next  = '0;
            end
          end
          default: state_next = SEARCH;
        endcase
      end
    end
  end

  assign o_sample_valid = sample_valid;
  assign o_lock         = (state == LOCK);
  assign o_delay        = delay;
  assign o_err_count    = err_count;
  assign o_bit_count    = bit_count;

endmodule
`default_nettype wire

// File: tb/tb_rx_control.sv
`default_nettype none
// ==== tb_rx_control: randomized scoreboard bench for rx_control (rev 1.0) ====
module tb_rx_control;

  localparam int OS         = 4;
  localparam int PH_W       = 2;
  localparam int MAX_DELAY  = 512;
  localparam int DLY_W      = 9;
  localparam int WINDOW     = 64;
  localparam int LOSS_THR   = 8;
  localparam int CNT_W      = 32;
  localparam int CNT_W_S    = 4;
  localparam int CHAN_DELAY = 37;

  logic              clock = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_enable = 1'b0;
  logic [PH_W-1:0]   i_phase = 2'd2;
  logic              i_rx_bit = 1'b0;
  logic              i_ref_bit = 1'b0;

  logic              o_sample_valid, o_lock;
  logic [DLY_W-1:0]  o_delay;
  logic [CNT_W-1:0]  o_err_count, o_bit_count;
  logic              s_sample_valid, s_lock;
  logic [DLY_W-1:0]  s_delay;
  logic [CNT_W_S-1:0] s_err_count, s_bit_count;

  rx_control #(.OS(OS), .PH_W(PH_W), .MAX_DELAY(MAX_DELAY), .DLY_W(DLY_W),
               .WINDOW(WINDOW), .LOSS_THR(LOSS_THR), .CNT_W(CNT_W)) dut (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_phase(i_phase),
    .i_rx_bit(i_rx_bit), .i_ref_bit(i_ref_bit), .o_sample_valid(o_sample_valid),
    .o_lock(o_lock), .o_delay(o_delay), .o_err_count(o_err_count), .o_bit_count(o_bit_count));

  // Narrow-counter copy on the same stimulus, for saturation.
  rx_control #(.OS(OS), .PH_W(PH_W), .MAX_DELAY(MAX_DELAY), .DLY_W(DLY_W),
               .WINDOW(WINDOW), .LOSS_THR(LOSS_THR), .CNT_W(CNT_W_S)) dut_s (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_phase(i_phase),
    .i_rx_bit(i_rx_bit), .i_ref_bit(i_ref_bit), .o_sample_valid(s_sample_valid),
    .o_lock(s_lock), .o_delay(s_delay), .o_err_count(s_err_count), .o_bit_count(s_bit_count));

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic longint sat(input longint v, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (v > m) ? m : v;
  endfunction

  // ---------------- reference model: one call per received symbol ----------------
  bit     m_lock;
  int     m_cand, m_delay, m_win_n, m_win_e, m_phase;
  longint m_errc, m_bitc;
  bit     m_hist[$];

  function automatic void model_reset();
    m_lock = 0; m_cand = 0; m_delay = 0; m_win_n = 0; m_win_e = 0;
    m_phase = 0; m_errc = 0; m_bitc = 0;
    m_hist.delete();
  endfunction

  function automatic void model_sample(input bit rx, input bit rf);
    int d;
    bit e;
    m_hist.push_front(rf);
    if (m_hist.size() > MAX_DELAY) void'(m_hist.pop_back());
    d = m_lock ? m_delay : m_cand;
    e = rx ^ ((d < m_hist.size()) ? m_hist[d] : 1'b0);
    m_win_n++;
    m_win_e += int'(e);
    if (m_lock) begin
      m_bitc++;
      m_errc += longint'(e);
    end
    if (m_win_n == WINDOW) begin
      if (!m_lock && m_win_e == 0) begin
        m_lock  = 1;
        m_delay = m_cand;
      end else if (!m_lock) begin
        m_cand = (m_cand + 1) % MAX_DELAY;
      end else if (m_win_e > LOSS_THR) begin
        m_lock = 0;
        m_cand = 0;
      end
      m_win_n = 0;
      m_win_e = 0;
    end
  endfunction

  // ---------------- scoreboard and monitor ----------------
  typedef struct {
    int     cyc;
    bit     lock;
    int     delay;
    longint errc;
    longint bitc;
  } exp_t;

  exp_t sb_q[$];
  exp_t pend;
  exp_t mon_it;
  bit   pend_v = 0;
  bit   en_edge = 0;
  int   strobe_cyc[$];

  always @(posedge clock) en_edge <= i_enable;

  always @(negedge clock) begin
    if (pend_v && en_edge && !i_reset) begin
      chk("lock", o_lock, pend.lock);
      chk("delay", o_delay, pend.delay);
      chk("err_count", o_err_count, sat(pend.errc, CNT_W));
      chk("bit_count", o_bit_count, sat(pend.bitc, CNT_W));
      chk("err_count_w4", s_err_count, sat(pend.errc, CNT_W_S));
      chk("bit_count_w4", s_bit_count, sat(pend.bitc, CNT_W_S));
      pend_v = 0;
    end
    if (o_sample_valid) begin
      strobe_cyc.push_back(cyc);
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_strobe at cycle %0d: got strobe, expected none", cyc);
      end else begin
        mon_it = sb_q.pop_front();
        chk("strobe_cycle", cyc, mon_it.cyc);
        chk("strobe_w4", s_sample_valid, 1);
        pend   = mon_it;
        pend_v = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [8:0] prbs;
  bit         tx_hist[$];
  int         ph_drive = 2;

  // One symbol: bits held for OS enabled cycles, i_phase switching at chg_at.
  task automatic send_symbol(input bit rx, input bit rf, input int ph_a, input int ph_b,
                             input int chg_at);
    exp_t it;
    for (int j = 0; j < OS; j++) begin
      i_enable  = 1'b1;
      i_rx_bit  = rx;
      i_ref_bit = rf;
      i_phase   = (j < chg_at) ? PH_W'(ph_a) : PH_W'(ph_b);
      @(posedge clock);
      #1;
      if (j == m_phase) begin
        model_sample(rx, rf);
        it.cyc   = cyc;
        it.lock  = m_lock;
        it.delay = m_delay;
        it.errc  = m_errc;
        it.bitc  = m_bitc;
        sb_q.push_back(it);
      end
    end
    m_phase = ph_b;
  endtask

  task automatic run_sym(input bit flip, input int ph_next, input int chg_at);
    bit rf, rx;
    rf   = prbs[8] ^ prbs[4];
    prbs = {prbs[7:0], rf};
    tx_hist.push_front(rf);
    if (tx_hist.size() > CHAN_DELAY + 1) void'(tx_hist.pop_back());
    rx = (tx_hist.size() > CHAN_DELAY) ? tx_hist[CHAN_DELAY] : 1'b0;
    send_symbol(rx ^ flip, rf, ph_drive, ph_next, chg_at);
    ph_drive = ph_next;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, o_sample_valid, 0);
    chk({tag, "_lock"}, o_lock, 0);
    chk({tag, "_delay"}, o_delay, 0);
    chk({tag, "_err"}, o_err_count, 0);
    chk({tag, "_bits"}, o_bit_count, 0);
    chk({tag, "_bits_w4"}, s_bit_count, 0);
  endtask

  task automatic check_model_outputs(input string tag);
    chk({tag, "_lock"}, o_lock, m_lock);
    chk({tag, "_delay"}, o_delay, m_delay);
    chk({tag, "_err"}, o_err_count, m_errc);
    chk({tag, "_bits"}, o_bit_count, m_bitc);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int     g, n0, rph;
    longint e0, b0;

    prbs = 9'($urandom_range(1, 511));
    model_reset();
    i_reset  = 1'b1;
    i_enable = 1'b1;
    repeat (3) begin
      @(posedge clock);
      #1;
      check_zero("reset");
    end
    i_reset = 1'b0;

    // Error-free acquisition at the channel delay.
    g = 0;
    while (!m_lock && g < 5000) begin
      run_sym(0, 2, 0);
      g++;
    end
    chk("model_acquired", m_lock, 1);
    repeat (30) run_sym(0, 2, 0);
    chk("acq_lock", o_lock, 1);
    chk("acq_delay", o_delay, CHAN_DELAY);
    chk("acq_err", o_err_count, 0);
    chk("sat_bits_w4", s_bit_count, 15);

    // One flipped bit in every 16 keeps lock.
    e0 = m_errc;
    b0 = m_bitc;
    for (int k = 0; k < 256; k++) run_sym(k % 16 == 0, 2, 0);
    chk("ratio_lock", o_lock, 1);
    chk("ratio_err", o_err_count, e0 + 16);
    chk("ratio_bits", o_bit_count, b0 + 256);

    // Enable low: everything holds, no strobes.
    i_enable = 1'b0;
    repeat (10) begin
      i_rx_bit  = 1'($urandom);
      i_ref_bit = 1'($urandom);
      @(negedge clock);
      chk("disabled_no_strobe", o_sample_valid, 0);
      @(posedge clock);
      #1;
    end
    check_model_outputs("disabled_hold");

    // Phase 2 -> 0 at a boundary, then 0 -> 3 at ph_cnt = 1.
    run_sym(0, 0, 0);
    n0 = strobe_cyc.size();
    run_sym(0, 3, 1);
    run_sym(0, 3, 0);
    run_sym(0, 2, 0);
    if (strobe_cyc.size() >= n0 + 2) begin
      chk("phase_gap_0_to_3", strobe_cyc[n0 + 1] - strobe_cyc[n0], 7);
    end else begin
      chk("phase_strobe_count", strobe_cyc.size(), n0 + 2);
    end

    // Random phase moves and sparse random errors.
    for (int k = 0; k < 160; k++) begin
      rph = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, OS - 1)) : ph_drive;
      run_sym($urandom_range(0, 63) == 0, rph, int'($urandom_range(0, OS - 1)));
    end
    run_sym(0, 2, 0);
    run_sym(0, 2, 0);
    check_model_outputs("random_phase");

    // Every other bit flipped: lock drops at a window end, counters freeze.
    g = 0;
    while (m_lock && g < 300) begin
      run_sym(g % 2 == 0, 2, 0);
      g++;
    end
    chk("lost_lock", o_lock, 0);
    e0 = m_errc;
    b0 = m_bitc;
    repeat (20) run_sym(0, 2, 0);
    chk("frozen_err", o_err_count, e0);
    chk("frozen_bits", o_bit_count, b0);

    // Relock from candidate 0; counters continue from held values.
    g = 0;
    while (!m_lock && g < 5000) begin
      run_sym(0, 2, 0);
      g++;
    end
    repeat (8) run_sym(0, 2, 0);
    chk("relock_lock", o_lock, 1);
    chk("relock_delay", o_delay, CHAN_DELAY);
    chk("relock_bits", o_bit_count, b0 + 8);

    // One-cycle reset while locked discards everything.
    i_reset = 1'b1;
    sb_q.delete();
    pend_v = 0;
    @(posedge clock);
    #1;
    check_zero("midreset");
    i_reset = 1'b0;
    model_reset();
    repeat (140) run_sym($urandom_range(0, 3) == 0, 2, 0);
    check_model_outputs("post_reset");

    i_enable = 1'b0;
    repeat (3) @(negedge clock);
    chk("scoreboard_drained", sb_q.size() + int'(pend_v), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
